// File: rtl/axis_burst_arbiter.sv
// Round-robin burst arbiter: drains BURST_LEN beats from one of two FWFT source FIFOs onto AXI-Stream.
// First beat valid one cycle after eligibility seen in IDLE; tready low holds the beat, counter and pops.
module axis_burst_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 11
) (
    input  logic                    m00_axis_aclk,
    input  logic                    m00_axis_areset,
    input  logic                    cfg_en,
    input  logic [CNT_WIDTH-1:0]    s0_count,
    input  logic [CNT_WIDTH-1:0]    s1_count,
    input  logic [DATA_WIDTH-1:0]   s0_rdata,
    input  logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic                    s0_rd_en,
    output logic                    s1_rd_en,
    output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                    m00_axis_tvalid,
    output logic                    m00_axis_tlast,
    input  logic                    m00_axis_tready,
    output logic                    busy,
    output logic                    grant
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] THRESH    = CNT_WIDTH'(BURST_LEN);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BEAT_W-1:0] beat;
    logic              last_grant;
    logic              elig0;
    logic              elig1;
    logic              start;
    logic              pick;
    logic              accept;
    logic              at_last;

    assign elig0   = (s0_count >= THRESH);
    assign elig1   = (s1_count >= THRESH);
    assign start   = (state == IDLE) && cfg_en && (elig0 || elig1);
    // With both eligible alternate; a lone eligible source wins regardless of history.
    assign pick    = (elig0 && elig1) ? ~last_grant : elig1;
    assign at_last = (beat == LAST_BEAT);

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BURST;
            BURST:   if (accept && at_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state == BURST);
        m00_axis_tvalid = busy;
        m00_axis_tstrb  = busy ? '1 : '0;
        m00_axis_tdata  = grant ? s1_rdata : s0_rdata;
        m00_axis_tlast  = busy && at_last;
        accept          = busy && m00_axis_tready;
        s0_rd_en        = accept && !grant;
        s1_rd_en        = accept && grant;
    end

    // Grant is latched at burst start so source count changes mid-burst are ignored.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            beat       <= '0;
        end else if (start) begin
            grant      <= pick;
            last_grant <= pick;
            beat       <= '0;
        end else if (accept) begin
            beat       <= at_last ? '0 : beat + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_burst_arbiter.sv
// Bench for axis_burst_arbiter: reset/threshold vector table plus scoreboarded burst sequences.
module tb_axis_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic [10:0] s0_count;
    logic [10:0] s1_count;
    logic [31:0] s0_rdata;
    logic [31:0] s1_rdata;
    logic        s0_rd_en;
    logic        s1_rd_en;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        busy;
    logic        grant;

    int checks = 0;
    int errors = 0;
    int beats_seen = 0;
    int exp_ptr [2];
    logic [15:0] src_ptr0 = 16'd0;
    logic [15:0] src_ptr1 = 16'd0;
    logic        prev_last = 1'b0;

    typedef struct {
        bit          src;
        logic [31:0] dat;
        bit          last;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic        cfg;
        logic [10:0] c0;
        logic [10:0] c1;
        logic        rdy;
        logic        vld;
        logic        bsy;
        logic        gnt;
        logic        lst;
        logic        rd0;
        logic        rd1;
    } vec_t;

    axis_burst_arbiter dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .cfg_en          (cfg_en),
        .s0_count        (s0_count),
        .s1_count        (s1_count),
        .s0_rdata        (s0_rdata),
        .s1_rdata        (s1_rdata),
        .s0_rd_en        (s0_rd_en),
        .s1_rd_en        (s1_rd_en),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready),
        .busy            (busy),
        .grant           (grant)
    );

    always #5 clk = ~clk;

    // FWFT source models: head word encodes source tag and pop index.
    assign s0_rdata = {16'hA0A0, src_ptr0};
    assign s1_rdata = {16'hB1B1, src_ptr1};
    always @(posedge clk) begin
        if (s0_rd_en) src_ptr0 <= src_ptr0 + 16'd1;
        if (s1_rd_en) src_ptr1 <= src_ptr1 + 16'd1;
    end

    function automatic logic [31:0] word(input bit src, input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return src ? {16'hB1B1, kk} : {16'hA0A0, kk};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_burst(input bit src);
        exp_t e;
        for (int j = 0; j < 16; j++) begin
            e.src  = src;
            e.dat  = word(src, exp_ptr[src]);
            e.last = (j == 15);
            exp_ptr[src]++;
            q.push_back(e);
        end
    endtask

    task automatic wait_beats(input int n, input int base_v);
        int k;
        k = 0;
        while ((beats_seen - base_v) < n && k < 100) begin
            step();
            k++;
        end
        check("beat_wait", 32'(beats_seen - base_v), 32'(n));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (q.size() != 0 && k < 400) begin
            step();
            k++;
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    // Output monitor: every accepted beat is scored against the queue.
    always @(negedge clk) begin
        exp_t e;
        check("tstrb", 32'(tstrb), tvalid ? 32'hF : 32'h0);
        check("tvalid_busy", 32'(tvalid), 32'(busy));
        check("tlast_gated", 32'(tlast & ~tvalid), 32'd0);
        if (prev_last) check("idle_gap", 32'(tvalid), 32'd0);
        if (tvalid && tready) begin
            if (q.size() == 0) begin
                check("unexpected_beat", 32'(tvalid && tready), 32'd0);
            end else begin
                e = q.pop_front();
                check("tdata", tdata, e.dat);
                check("tlast", 32'(tlast), 32'(e.last));
                check("grant", 32'(grant), 32'(e.src));
                check("rd_en_granted", 32'(e.src ? s1_rd_en : s0_rd_en), 32'd1);
                check("rd_en_other", 32'(e.src ? s0_rd_en : s1_rd_en), 32'd0);
            end
            beats_seen++;
        end else begin
            check("rd_en_no_hs", 32'({s1_rd_en, s0_rd_en}), 32'd0);
        end
        prev_last = tvalid && tready && tlast;
    end

    initial begin
        vec_t        vecs [7];
        logic [31:0] hold;
        int          base;
        int          k;

        exp_ptr[0] = 0;
        exp_ptr[1] = 0;

        //            cfg  c0      c1      rdy   vld   bsy   gnt   lst   rd0   rd1
        vecs[0] = '{1'b1, 11'd15, 11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 11'd15, 11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 11'd16, 11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 11'd16, 11'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 11'd0,  11'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 11'd0,  11'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 11'd16, 11'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset held with eligible sources: nothing may start.
        rst = 1'b1; cfg_en = 1'b1; tready = 1'b1; s0_count = 11'd16; s1_count = 11'd16;
        repeat (4) begin
            step();
            check("rst_tvalid", 32'(tvalid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_grant", 32'(grant), 32'd0);
            check("rst_rd_en", 32'({s1_rd_en, s0_rd_en}), 32'd0);
            check("rst_tlast", 32'(tlast), 32'd0);
        end
        s0_count = 11'd15; s1_count = 11'd0; tready = 1'b0;
        step();
        rst = 1'b0;

        // Threshold, start latency and grant stability under count changes.
        for (int i = 0; i < 7; i++) begin
            cfg_en = vecs[i].cfg; s0_count = vecs[i].c0; s1_count = vecs[i].c1; tready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d_tvalid", i), 32'(tvalid), 32'(vecs[i].vld));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_tlast", i), 32'(tlast), 32'(vecs[i].lst));
            check($sformatf("vec%0d_rd_en", i), 32'({s1_rd_en, s0_rd_en}), 32'({vecs[i].rd1, vecs[i].rd0}));
            step();
        end

        // Backpressure at beat 5, cfg_en dropped at beat 8.
        cfg_en = 1'b1;
        push_burst(1'b0);
        base = beats_seen;
        tready = 1'b1;
        wait_beats(4, base);
        tready = 1'b0;
        #1;
        hold = tdata;
        repeat (3) begin
            step();
            check("bp_tvalid", 32'(tvalid), 32'd1);
            check("bp_tdata", tdata, hold);
            check("bp_tlast", 32'(tlast), 32'd0);
            check("bp_beats", 32'(beats_seen - base), 32'd4);
        end
        tready = 1'b1;
        wait_beats(7, base);
        cfg_en = 1'b0;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        check("bp_done", 32'(busy), 32'd0);
        check("bp_total", 32'(beats_seen - base), 32'd16);
        check("bp_queue", 32'(q.size()), 32'd0);
        repeat (8) begin
            step();
            check("cfg_off_busy", 32'(busy), 32'd0);
        end

        // Round-robin from a fresh reset: s0, s1, s0, s1.
        rst = 1'b1;
        step();
        s0_count = 11'd64; s1_count = 11'd64; cfg_en = 1'b1; tready = 1'b1;
        push_burst(1'b0); push_burst(1'b1); push_burst(1'b0); push_burst(1'b1);
        step();
        rst = 1'b0;
        drain("rr_drain");
        cfg_en = 1'b0;
        step();
        step();
        check("rr_idle", 32'(busy), 32'd0);

        // Reset mid-burst after 8 beats; arbitration restarts preferring s0.
        cfg_en = 1'b1;
        push_burst(1'b0);
        base = beats_seen;
        wait_beats(8, base);
        rst = 1'b1;
        #1;
        check("mr_tvalid", 32'(tvalid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rd_en", 32'({s1_rd_en, s0_rd_en}), 32'd0);
        check("mr_tlast", 32'(tlast), 32'd0);
        check("mr_leftover", 32'(q.size()), 32'd8);
        q.delete();
        exp_ptr[0] = exp_ptr[0] - 8;
        step();
        step();
        check("mr_popped", 32'(src_ptr0), 32'(exp_ptr[0]));
        push_burst(1'b0);
        push_burst(1'b1);
        rst = 1'b0;
        drain("mr_drain");
        cfg_en = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
